id_ex_stage: RTL



---
 rtl/mips_pkg.sv | 28 ++
 rtl/id_ex_stage_fwd_mux.sv | 37 +++
 rtl/id_ex_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU control codes, operand-B source encodings
// and default datapath/register-address widths.
package mips_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SRA = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1000,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_RT    = 2'b00,
        SRC_B_IMM   = 2'b01,
        SRC_B_SHAMT = 2'b10,
        SRC_B_RS    = 2'b11
    } src_b_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM result beats MEM/WB result beats the
// value latched from the register file; $0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] src_addr_i,
    input  logic [DW-1:0] reg_data_i,
    input  logic          exmem_reg_write_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_reg_write_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic [DW-1:0] fwd_data_o
);

    logic src_nz;
    logic hit_exmem;
    logic hit_memwb;

    assign src_nz    = (src_addr_i != '0);
    assign hit_exmem = src_nz && exmem_reg_write_i && (exmem_rd_i == src_addr_i);
    assign hit_memwb = src_nz && memwb_reg_write_i && (memwb_rd_i == src_addr_i);

    always_comb begin
        fwd_data_o = reg_data_i;
        if (hit_exmem) begin
            fwd_data_o = exmem_result_i;
        end else if (hit_memwb) begin
            fwd_data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand formation and load-use detection.
// Build option ID_EX_FORWARDING_EN: forwarding on; otherwise RAW hazards stall.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic [AW-1:0] id_rd_addr,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [3:0]    id_alu_op,
    input  logic          id_src_a_sel,
    input  logic [1:0]    id_src_b_sel,
    input  logic          id_imm_zext,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] alu_in_1,
    output logic [DW-1:0] alu_in_2,
    output logic [3:0]    alu_control_line,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic [AW-1:0] ex_rd_addr,
    output logic [DW-1:0] ex_store_data,
    output logic          hazard_stall
);

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic [3:0]    alu_op;
        logic          src_a_sel;
        logic [1:0]    src_b_sel;
        logic          imm_zext;
        logic [15:0]   imm;
        logic [4:0]    shamt;
        logic [AW-1:0] rs_addr;
        logic [AW-1:0] rt_addr;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
    } idex_t;

    idex_t idex_q;
    idex_t idex_d;

    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] shamt_ext;

    // An all-zero record is the bubble: nothing valid, no writes, $0 sources.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!stall) begin
            idex_d.valid     = id_valid;
            idex_d.reg_write = id_reg_write;
            idex_d.mem_read  = id_mem_read;
            idex_d.mem_write = id_mem_write;
            idex_d.alu_op    = id_alu_op;
            idex_d.src_a_sel = id_src_a_sel;
            idex_d.src_b_sel = id_src_b_sel;
            idex_d.imm_zext  = id_imm_zext;
            idex_d.imm       = id_imm;
            idex_d.shamt     = id_shamt;
            idex_d.rs_addr   = id_rs_addr;
            idex_d.rt_addr   = id_rt_addr;
            idex_d.rd_addr   = id_rd_addr;
            idex_d.rs_data   = id_rs_data;
            idex_d.rt_data   = id_rt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src_addr_i        (idex_q.rs_addr),
        .reg_data_i        (idex_q.rs_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_result_i    (memwb_result),
        .fwd_data_o        (rs_fwd)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src_addr_i        (idex_q.rt_addr),
        .reg_data_i        (idex_q.rt_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_result_i    (memwb_result),
        .fwd_data_o        (rt_fwd)
    );
`else
    // Without forwarding the stall logic keeps RAW pairs apart, so the latched
    // register-file values are already current.
    logic unused_fwd;

    assign rs_fwd     = idex_q.rs_data;
    assign rt_fwd     = idex_q.rt_data;
    assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                          idex_q.rs_addr, idex_q.rt_addr};
`endif

    assign imm_ext   = {{(DW-16){idex_q.imm[15] & ~idex_q.imm_zext}}, idex_q.imm};
    assign shamt_ext = {{(DW-5){1'b0}}, idex_q.shamt};

    assign alu_in_1 = idex_q.src_a_sel ? rt_fwd : rs_fwd;

    always_comb begin
        alu_in_2 = rt_fwd;
        case (idex_q.src_b_sel)
            SRC_B_RT:    alu_in_2 = rt_fwd;
            SRC_B_IMM:   alu_in_2 = imm_ext;
            SRC_B_SHAMT: alu_in_2 = shamt_ext;
            SRC_B_RS:    alu_in_2 = rs_fwd;
            default:     alu_in_2 = rt_fwd;
        endcase
    end

    assign ex_store_data    = rt_fwd;
    assign alu_control_line = idex_q.alu_op;
    assign ex_valid         = idex_q.valid;
    assign ex_reg_write     = idex_q.reg_write;
    assign ex_mem_read      = idex_q.mem_read;
    assign ex_mem_write     = idex_q.mem_write;
    assign ex_rd_addr       = idex_q.rd_addr;

    logic id_reads_rs;
    logic id_reads_rt;
    logic ex_rd_nz;
    logic ex_rd_match;
    logic load_use;

    assign id_reads_rs = id_uses_rs && (id_rs_addr != '0);
    assign id_reads_rt = id_uses_rt && (id_rt_addr != '0);
    assign ex_rd_nz    = (idex_q.rd_addr != '0);
    assign ex_rd_match = (id_uses_rs && (id_rs_addr == idex_q.rd_addr)) ||
                         (id_uses_rt && (id_rt_addr == idex_q.rd_addr));
    assign load_use    = idex_q.valid && idex_q.mem_read && ex_rd_nz && ex_rd_match;

`ifdef ID_EX_FORWARDING_EN
    assign hazard_stall = id_valid && load_use;
`else
    logic ex_raw;
    logic exmem_raw;

    assign ex_raw    = idex_q.valid && idex_q.reg_write &&
                       ((id_reads_rs && (id_rs_addr == idex_q.rd_addr)) ||
                        (id_reads_rt && (id_rt_addr == idex_q.rd_addr)));
    assign exmem_raw = exmem_reg_write &&
                       ((id_reads_rs && (id_rs_addr == exmem_rd)) ||
                        (id_reads_rt && (id_rt_addr == exmem_rd)));

    assign hazard_stall = id_valid && (load_use || ex_raw || exmem_raw);
`endif

`ifdef ID_EX_FORWARDING_EN
    logic unused_reads;
    assign unused_reads = id_reads_rs ^ id_reads_rt;
`endif

endmodule
